rr_arb4_8bit: RTL and testbench
===============================

RR_ARB4_8BIT -- requirements
Module: rr_arb4_8bit

Interface
REQ-001 Parameter MAX_BURST, default 4, legal 1..15: maximum beats accepted per grant before re-arbitration.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-004 req  input  4  request per requester; req[k] high means requester k has a beat on ik.
REQ-005 i0, i1, i2, i3  input  8 each  requester data buses.
REQ-006 ready  input  1  downstream accepts f when ready=1 and valid=1 in the same cycle.
REQ-007 grant  output  4  one-hot grant to the current owner; all-zero when no owner.
REQ-008 sel1, sel0  output  1 each  binary encoding of the owner index (sel1 = MSB), driving the 4:1 8-bit channel mux.
REQ-009 f  output  8  registered channel data.
REQ-010 valid  output  1  f holds an unaccepted beat.
REQ-011 busy  output  1  high whenever the state is GRANT.

Function
REQ-012 The block SHALL have two states, IDLE and GRANT, plus owner index g (2 bits), round-robin pointer ptr (2 bits) and beat counter cnt (4 bits).
REQ-013 In IDLE with req != 0, the block SHALL pick the first k with req[k]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); next cycle state=GRANT, g=k, cnt=0.
REQ-014 In IDLE with req == 0, the block SHALL remain in IDLE with grant=0.
REQ-015 grant SHALL equal one-hot(g) and {sel1,sel0} SHALL equal g while in GRANT; in IDLE grant SHALL be 0 and {sel1,sel0} SHALL hold their last value.
REQ-016 Term "slot free" = (valid==0) or (ready==1).
REQ-017 In GRANT, when req[g]=1, cnt<MAX_BURST and the slot is free, the block SHALL load f<=i_g, set valid<=1 and increment cnt (a load).
REQ-018 When the slot is free and no load occurs, valid SHALL go to 0 the next cycle.
REQ-019 While valid=1 and ready=0, f and valid SHALL remain unchanged, and no load SHALL occur.
REQ-020 In GRANT, when (req[g]==0 or cnt==MAX_BURST) and the slot is free, the block SHALL release: next state IDLE, ptr<=g+1 (mod 4), grant<=0.
REQ-021 A beat already loaded SHALL be delivered even if req[g] falls before acceptance; release waits for that beat's acceptance.
REQ-022 Latency: req rising in an IDLE cycle N gives grant at N+1 and the first valid beat at N+2; with ready held at 1, one beat per cycle follows.
REQ-023 After the last beat of a MAX_BURST grant is accepted, the block SHALL spend one IDLE cycle before the next grant.
REQ-024 With all four requesters asserting continuously, grants SHALL rotate 0,1,2,3,0,... with no requester starved.
REQ-025 Changes on req[k] for k != g during GRANT SHALL have no effect until the next IDLE arbitration.

Reset
REQ-026 On a clk edge with rst_n=0, the block SHALL set: state=IDLE, ptr=0, g=0, cnt=0, grant=0, sel1=0, sel0=0, f=8'h00, valid=0, busy=0.
REQ-027 Reset SHALL win over every other event, including mid-burst and while valid=1 with ready=0; a pending beat SHALL be discarded.
REQ-028 The first arbitration after reset SHALL give requester 0 the highest priority.

Verification
REQ-029 Single requester: after reset, req=4'b0100, i2=8'hA5, ready=1 -> grant=4'b0100, sel1=1, sel0=0 one cycle later; f=8'hA5 with valid=1 one cycle after that.
REQ-030 Burst cap: req=4'b0001 held, ready=1, MAX_BURST=4 -> exactly 4 beats, then grant=0 for one cycle, then requester 0 is granted again.
REQ-031 Round-robin: req=4'b1111 held, ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, each holding for 4 beats.
REQ-032 Backpressure: during a burst with f=8'h3C and valid=1, ready=0 for 3 cycles -> f=8'h3C and valid=1 are stable and cnt is unchanged; the next beat loads on the cycle ready returns.
REQ-033 Early drop: requester 1 granted and req[1] drops after beat 2 while that beat waits on ready=0 -> beat 2 is delivered, then release with ptr=2.
REQ-034 Reset mid-burst: rst_n=0 for one edge with valid=1 and grant=4'b1000 -> all outputs 0 next cycle; with req=4'b1001, requester 0 is granted.

Source files
------------

// File: rtl/rr_arb4_8bit.sv
// Four-requester round-robin arbiter that moves bursts of up to MAX_BURST
// 8-bit beats from the owning requester onto one registered output channel.
module rr_arb4_8bit #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [7:0] i0,
    input  logic [7:0] i1,
    input  logic [7:0] i2,
    input  logic [7:0] i3,
    input  logic       ready,
    output logic [3:0] grant,
    output logic       sel1,
    output logic       sel0,
    output logic [7:0] f,
    output logic       valid,
    output logic       busy,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] g;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] pick;
    logic [7:0] data_g;
    logic       slot_free;

    // Handshake: a beat on f transfers on any rising edge where valid=1 and
    // ready=1; while valid=1 and ready=0, f and valid hold their values.
    assign slot_free = !valid || ready;
    assign dbg_state = state;

    // Walk from ptr+3 down to ptr so the nearest requester to ptr wins.
    always_comb begin
        pick = ptr;
        for (int j = 3; j >= 0; j--) begin
            if (req[ptr + 2'(j)]) pick = ptr + 2'(j);
        end
    end

    always_comb begin
        case (g)
            2'd0:    data_g = i0;
            2'd1:    data_g = i1;
            2'd2:    data_g = i2;
            default: data_g = i3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            g     <= 2'd0;
            cnt   <= 4'd0;
            grant <= 4'd0;
            sel1  <= 1'b0;
            sel0  <= 1'b0;
            f     <= 8'h00;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (slot_free) valid <= 1'b0;
                    if (|req) begin
                        state        <= GRANT;
                        g            <= pick;
                        cnt          <= 4'd0;
                        grant        <= 4'b0001 << pick;
                        {sel1, sel0} <= pick;
                        busy         <= 1'b1;
                    end
                end
                GRANT: begin
                    if (slot_free) begin
                        if (req[g] && (cnt < 4'(MAX_BURST))) begin
                            f     <= data_g;
                            valid <= 1'b1;
                            cnt   <= cnt + 4'd1;
                        end else begin
                            // Any loaded beat has just been accepted, so release is safe.
                            valid <= 1'b0;
                            state <= IDLE;
                            ptr   <= g + 2'd1;
                            grant <= 4'd0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb4_8bit.sv
// Bench for rr_arb4_8bit: vector table, directed corner sequences and a
// randomized run against a requester-level reference model.
module tb_rr_arb4_8bit;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic        ready = 1'b0;
    logic [31:0] ibus = 32'd0;
    logic [3:0]  grant;
    logic        sel1, sel0, valid, busy, dbg_state;
    logic [7:0]  f;

    int total = 0;
    int bad = 0;

    rr_arb4_8bit #(.MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(ibus[7:0]), .i1(ibus[15:8]), .i2(ibus[23:16]), .i3(ibus[31:24]),
        .ready(ready), .grant(grant), .sel1(sel1), .sel0(sel0),
        .f(f), .valid(valid), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: owner = -1 means nobody holds the channel.
    int         m_owner = -1;
    int         m_ptr = 0;
    int         m_cnt = 0;
    int         m_sel = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_f = 8'h00;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [7:0] d[4];
        d[0] = ibus[7:0]; d[1] = ibus[15:8]; d[2] = ibus[23:16]; d[3] = ibus[31:24];
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
            m_valid = 1'b0; m_f = 8'h00;
            exp_q.delete();
        end else if (m_owner < 0) begin
            m_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
                int k;
                k = (m_ptr + j) % 4;
                if (req[k]) begin
                    m_owner = k; m_sel = k; m_cnt = 0;
                    break;
                end
            end
        end else if (!m_valid || ready) begin
            if (req[m_owner] && m_cnt < MB) begin
                m_f = d[m_owner]; m_valid = 1'b1; m_cnt++;
                exp_q.push_back(m_f);
            end else begin
                m_valid = 1'b0;
                m_ptr = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end
    endtask

    // One clock: score accepted beat, advance model, compare after the edge.
    task automatic tick();
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) chk("sb_extra_beat", 32'd1, 32'd0);
            else chk("sb_beat", f, exp_q.pop_front());
        end
        @(posedge clk);
        model_update();
        #1;
        chk("m_grant", grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("m_sel", {sel1, sel0}, m_sel);
        chk("m_valid", valid, m_valid);
        chk("m_f", f, m_f);
        chk("m_busy", busy, (m_owner >= 0) ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'd0; ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic        ready;
        logic [31:0] ibus;
        logic [3:0]  g;
        logic [1:0]  s;
        logic        v;
        logic [7:0]  f;
        logic        b;
    } vec_t;

    vec_t tbl[13];
    logic [3:0] rr_exp[5];

    function automatic vec_t mk(logic r, logic [3:0] q, logic rd, logic [31:0] ib,
                                logic [3:0] eg, logic [1:0] es, logic ev, logic [7:0] ef, logic eb);
        vec_t v;
        v.rst_n = r; v.req = q; v.ready = rd; v.ibus = ib;
        v.g = eg; v.s = es; v.v = ev; v.f = ef; v.b = eb;
        return v;
    endfunction

    initial begin
        int n;
        logic [3:0] prev;

        // Single requester 2, then a capped burst from requester 0, then reset.
        tbl[0]  = mk(0, 4'b0000, 1, 32'h0,        4'b0000, 2'd0, 0, 8'h00, 0);
        tbl[1]  = mk(1, 4'b0100, 1, 32'h00A50000, 4'b0100, 2'd2, 0, 8'h00, 1);
        tbl[2]  = mk(1, 4'b0100, 1, 32'h00A50000, 4'b0100, 2'd2, 1, 8'hA5, 1);
        tbl[3]  = mk(1, 4'b0000, 1, 32'h0,        4'b0000, 2'd2, 0, 8'hA5, 0);
        tbl[4]  = mk(1, 4'b0001, 1, 32'h11,       4'b0001, 2'd0, 0, 8'hA5, 1);
        tbl[5]  = mk(1, 4'b0001, 1, 32'h21,       4'b0001, 2'd0, 1, 8'h21, 1);
        tbl[6]  = mk(1, 4'b0001, 1, 32'h22,       4'b0001, 2'd0, 1, 8'h22, 1);
        tbl[7]  = mk(1, 4'b0001, 1, 32'h23,       4'b0001, 2'd0, 1, 8'h23, 1);
        tbl[8]  = mk(1, 4'b0001, 1, 32'h24,       4'b0001, 2'd0, 1, 8'h24, 1);
        tbl[9]  = mk(1, 4'b0001, 1, 32'h25,       4'b0000, 2'd0, 0, 8'h24, 0);
        tbl[10] = mk(1, 4'b0001, 1, 32'h26,       4'b0001, 2'd0, 0, 8'h24, 1);
        tbl[11] = mk(1, 4'b0001, 1, 32'h31,       4'b0001, 2'd0, 1, 8'h31, 1);
        tbl[12] = mk(0, 4'b0001, 1, 32'h0,        4'b0000, 2'd0, 0, 8'h00, 0);

        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n; req = tbl[i].req; ready = tbl[i].ready; ibus = tbl[i].ibus;
            tick();
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_sel", i), {sel1, sel0}, tbl[i].s);
            chk($sformatf("tbl%0d_valid", i), valid, tbl[i].v);
            chk($sformatf("tbl%0d_f", i), f, tbl[i].f);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
        end

        // Backpressure holds f/valid, next beat loads when ready returns.
        do_reset();
        req = 4'b0001; ready = 1'b1; ibus = 32'h3C;
        tick(); tick();
        chk("bp_first", f, 8'h3C);
        ready = 1'b0; ibus = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_f", f, 8'h3C);
            chk("bp_hold_valid", valid, 1'b1);
        end
        ready = 1'b1;
        tick();
        chk("bp_next_f", f, 8'h55);
        chk("bp_next_valid", valid, 1'b1);

        // Early drop by requester 1 while beat 2 waits.
        do_reset();
        req = 4'b0010; ready = 1'b1; ibus = 32'h0000A100;
        tick();
        chk("drop_grant", grant, 4'b0010);
        tick();
        chk("drop_beat1", f, 8'hA1);
        ibus = 32'h0000A200;
        tick();
        chk("drop_beat2", f, 8'hA2);
        req = 4'b0000; ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drop_wait_f", f, 8'hA2);
            chk("drop_wait_grant", grant, 4'b0010);
        end
        ready = 1'b1;
        tick();
        chk("drop_release", grant, 4'b0000);
        chk("drop_release_valid", valid, 1'b0);
        req = 4'b1111;
        tick();
        chk("drop_next_ptr2", grant, 4'b0100);

        // Reset mid-burst with a stalled beat.
        do_reset();
        req = 4'b1000; ready = 1'b1; ibus = 32'h77000000;
        tick(); tick();
        ready = 1'b0;
        tick();
        chk("rst_pre_grant", grant, 4'b1000);
        chk("rst_pre_valid", valid, 1'b1);
        rst_n = 1'b0; req = 4'b1001;
        tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_sel", {sel1, sel0}, 2'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_f", f, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1; ready = 1'b1;
        tick();
        chk("rst_then_req0", grant, 4'b0001);

        // Round-robin rotation with everyone requesting.
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        do_reset();
        req = 4'b1111; ready = 1'b1;
        n = 0; prev = 4'd0;
        for (int c = 0; c < 32; c++) begin
            ibus = $urandom;
            tick();
            if (grant != 4'd0 && prev == 4'd0 && n < 5) begin
                chk($sformatf("rr_order%0d", n), grant, rr_exp[n]);
                n++;
            end
            prev = grant;
        end
        chk("rr_count", n, 5);

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) != 0);
            ibus = $urandom;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        rst_n = 1'b1; req = 4'd0; ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
